// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order imem reads,
// buffers returned words and hands {pc, instr} to decode; handles redirects.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        fetch_fault
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, FAULT} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  state_t        state;
  logic [1:0]    rst_sync;
  logic [31:0]   pc;
  logic [CW-1:0] inflight, drop, fifo_cnt, inflight_rsp;
  fetch_t        fifo_q [DEPTH];
  logic [31:0]   tag_q  [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic          redir, accept, rsp_hit, push, pop;

  // redirect wins over everything else in the cycle, including the request
  assign redir          = redir_valid && (state != FAULT);
  assign imem_req_valid = rst_sync[1] && (state == RUN) && !redir_valid &&
                          ((inflight + fifo_cnt) < DEPTH_C);
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_hit        = imem_rsp_valid && (inflight != '0);
  assign push           = rsp_hit && (state == RUN) && !redir;
  assign if_valid       = (fifo_cnt != '0);
  assign pop            = if_valid && if_ready;
  assign inflight_rsp   = inflight - CW'(rsp_hit);
  assign if_pc          = if_valid ? fifo_q[rd_ptr].pc    : '0;
  assign if_instr       = if_valid ? fifo_q[rd_ptr].instr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  // storage only; occupancy and pointers live in the control block below
  always_ff @(posedge clk) begin
    if (accept) tag_q[tag_wr] <= pc;
    if (push)   fifo_q[wr_ptr] <= '{pc: tag_q[tag_rd], instr: imem_rsp_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      inflight    <= '0;
      drop        <= '0;
      fifo_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      fetch_fault <= 1'b0;
    end else if (redir) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      inflight <= inflight_rsp;
      drop     <= inflight_rsp;
      if (redir_target[1:0] != 2'b00) begin
        state       <= FAULT;
        fetch_fault <= 1'b1;
      end else begin
        pc    <= redir_target;
        state <= (inflight_rsp != '0) ? DRAIN : RUN;
      end
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            tag_wr <= tag_wr + 1'b1;
            pc     <= pc + 32'd4;
          end
          if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            tag_rd <= tag_rd + 1'b1;
          end
          if (pop) rd_ptr <= rd_ptr + 1'b1;
          inflight <= inflight + CW'(accept) - CW'(rsp_hit);
          fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
        DRAIN: begin
          if (rsp_hit) begin
            inflight <= inflight_rsp;
            drop     <= drop - 1'b1;
            if (drop == CW'(1)) state <= RUN;
          end
        end
        default: begin
          if (rsp_hit) inflight <= inflight_rsp;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: queue-based transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pc_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] pc; bit stale; } out_t;

  logic clk = 0;
  logic rst_n = 0;
  logic redir_valid = 0;
  logic [31:0] redir_target = '0;
  logic imem_req_valid;
  logic [31:0] imem_req_addr;
  logic imem_req_ready = 0;
  logic imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = '0;
  logic if_valid;
  logic [31:0] if_pc, if_instr;
  logic if_ready = 0;
  logic fetch_fault;

  logic w_req_valid, w_if_valid, w_fault;
  logic [31:0] w_req_addr, w_if_pc, w_if_instr;
  logic w_rsp_valid = 0;
  logic [31:0] w_rsp_data = '0;
  logic w_one = 1'b1, w_zero = 1'b0;
  logic [31:0] w_zero32 = '0;

  pc_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .redir_valid(redir_valid), .redir_target(redir_target),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .if_ready(if_ready), .fetch_fault(fetch_fault));

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst_n(rst_n), .redir_valid(w_zero), .redir_target(w_zero32),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(w_one), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .if_valid(w_if_valid), .if_pc(w_if_pc),
    .if_instr(w_if_instr), .if_ready(w_one), .fetch_fault(w_fault));

  always #5 clk = ~clk;

  int checks = 0, passes = 0, fails = 0;
  int p_rsp = 0;
  // model state
  out_t oq[$];
  ent_t fq[$];
  logic [31:0] mpc;
  bit mfault;
  int men;
  bit exp_req;
  logic [31:0] mq[$];
  // DUT-observed logs
  logic [31:0] acc_log[$];
  ent_t pop_log[$];
  logic [31:0] w_log[$];
  bit last_req;
  bit w_pend = 0;
  logic [31:0] w_pend_addr = '0;

  function automatic logic [31:0] hash(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] aget(int i);
    return (i < acc_log.size()) ? acc_log[i] : 32'hBAD0_BAD1;
  endfunction
  function automatic ent_t pget(int i);
    ent_t e = '{pc: 32'hBAD0_BAD1, instr: 32'hBAD0_BAD1};
    if (i < pop_log.size()) e = pop_log[i];
    return e;
  endfunction
  function automatic bit has_stale();
    foreach (oq[i]) if (oq[i].stale) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    oq.delete(); fq.delete(); mpc = RPC; mfault = 0; men = 0;
  endtask

  task automatic check();
    ent_t h;
    if (!rst_n) model_reset();
    exp_req = rst_n && men >= 2 && !mfault && !has_stale() && !redir_valid &&
              (oq.size() + fq.size() < DEPTH);
    h = (fq.size() > 0) ? fq[0] : '0;
    cmp("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) cmp("req_addr", imem_req_addr, mpc);
    cmp("if_valid", 32'(if_valid), 32'(fq.size() > 0));
    cmp("if_pc", if_pc, h.pc);
    cmp("if_instr", if_instr, h.instr);
    cmp("fetch_fault", 32'(fetch_fault), 32'(mfault));
    if (imem_req_valid && imem_req_ready) acc_log.push_back(imem_req_addr);
    if (if_valid && if_ready) pop_log.push_back('{pc: if_pc, instr: if_instr});
    last_req = imem_req_valid;
  endtask

  task automatic model_update();
    bit acc, rsp, pop;
    out_t o;
    if (!rst_n) return;
    acc = exp_req && imem_req_ready;
    rsp = imem_rsp_valid && oq.size() > 0;
    pop = fq.size() > 0 && if_ready;
    if (men < 2) men++;
    if (redir_valid && !mfault) begin
      if (rsp) void'(oq.pop_front());
      fq.delete();
      foreach (oq[i]) oq[i].stale = 1;
      if (redir_target[1:0] != 2'b00) mfault = 1;
      else mpc = redir_target;
    end else begin
      if (pop) void'(fq.pop_front());
      if (rsp) begin
        o = oq.pop_front();
        if (!o.stale && !mfault) fq.push_back('{pc: o.pc, instr: imem_rsp_data});
      end
      if (acc) begin
        oq.push_back('{pc: mpc, stale: 0});
        mq.push_back(mpc);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  // one cycle: drive memory responses, compare, advance the model on the edge
  task automatic step();
    imem_rsp_valid = 0;
    imem_rsp_data  = $urandom;
    if (mq.size() > 0 && $urandom_range(99) < p_rsp) begin
      imem_rsp_valid = 1;
      imem_rsp_data  = hash(mq.pop_front());
    end
    w_rsp_valid = w_pend;
    w_rsp_data  = hash(w_pend_addr);
    #1;
    check();
    w_pend = rst_n && w_req_valid;
    w_pend_addr = w_req_addr;
    if (w_pend) w_log.push_back(w_req_addr);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0; redir_valid = 0; mq.delete();
    step();
    rst_n = 1;
    acc_log.delete(); pop_log.delete();
  endtask

  initial begin
    int n;
    ent_t e;
    model_reset();
    @(negedge clk);
    repeat (3) step();
    cmp("reset_req_valid", 32'(imem_req_valid), 32'd0);
    cmp("reset_if_pc", if_pc, 32'd0);
    cmp("reset_fault", 32'(fetch_fault), 32'd0);

    // straight-line fetch
    rst_n = 1; imem_req_ready = 1; if_ready = 1; p_rsp = 100;
    acc_log.delete(); pop_log.delete();
    repeat (14) step();
    for (int i = 0; i < 4; i++) begin
      e = pget(i);
      cmp("seq_addr", aget(i), 32'(i * 4));
      cmp("seq_pop_pc", e.pc, 32'(i * 4));
      cmp("seq_pop_instr", e.instr, hash(32'(i * 4)));
    end

    // decode backpressure
    do_reset();
    if_ready = 0; imem_req_ready = 1; p_rsp = 100;
    repeat (12) step();
    cmp("bp_req_count", acc_log.size(), 32'd2);
    if_ready = 1;
    repeat (10) step();
    cmp("bp_resume_addr", aget(2), 32'h8);
    cmp("bp_next_addr", aget(3), 32'hC);
    for (int i = 0; i < 3; i++) begin
      e = pget(i);
      cmp("bp_pop_pc", e.pc, 32'(i * 4));
    end

    // redirect with two requests in flight
    do_reset();
    imem_req_ready = 1; if_ready = 1; p_rsp = 0;
    repeat (6) step();
    cmp("redir_inflight", acc_log.size(), 32'd2);
    redir_valid = 1; redir_target = 32'h100;
    step();
    redir_valid = 0; p_rsp = 100;
    repeat (12) step();
    e = pget(0);
    cmp("redir_addr", aget(2), 32'h100);
    cmp("redir_pop_pc", e.pc, 32'h100);
    cmp("redir_pop_instr", e.instr, hash(32'h100));

    // redirect coinciding with a response and a would-be accept
    do_reset();
    imem_req_ready = 1; if_ready = 1; p_rsp = 0;
    n = 0;
    while (acc_log.size() < 1 && n < 10) begin step(); n++; end
    cmp("coinc_setup", acc_log.size(), 32'd1);
    redir_valid = 1; redir_target = 32'h200; p_rsp = 100;
    step();
    cmp("coinc_req_valid", 32'(last_req), 32'd0);
    redir_valid = 0;
    repeat (10) step();
    e = pget(0);
    cmp("coinc_addr", aget(1), 32'h200);
    cmp("coinc_pop_pc", e.pc, 32'h200);

    // misaligned redirect, then recovery through reset
    redir_valid = 1; redir_target = 32'h102;
    step();
    redir_valid = 0;
    n = acc_log.size();
    repeat (8) step();
    cmp("fault_flag", 32'(fetch_fault), 32'd1);
    cmp("fault_no_req", 32'(acc_log.size() - n), 32'd0);
    rst_n = 0; mq.delete();
    step();
    cmp("fault_cleared", 32'(fetch_fault), 32'd0);
    rst_n = 1; acc_log.delete(); pop_log.delete();
    repeat (8) step();
    cmp("restart_addr", aget(0), RPC);

    // randomized traffic
    p_rsp = 60;
    for (int c = 0; c < 3000; c++) begin
      imem_req_ready = $urandom_range(99) < 70;
      if_ready       = $urandom_range(99) < 70;
      redir_valid    = $urandom_range(99) < 5;
      redir_target   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(99) < 8) redir_target[1:0] = 2'b10;
      if ((mfault && $urandom_range(99) < 15) || $urandom_range(999) < 3) begin
        rst_n = 0; redir_valid = 0;
        step(); step();
        rst_n = 1;
      end else step();
    end

    // wrap-around instance: first requests after the first reset release
    cmp("wrap_addr0", (w_log.size() > 0) ? w_log[0] : 32'hBAD0_BAD1, 32'hFFFF_FFF8);
    cmp("wrap_addr1", (w_log.size() > 1) ? w_log[1] : 32'hBAD0_BAD1, 32'hFFFF_FFFC);
    cmp("wrap_addr2", (w_log.size() > 2) ? w_log[2] : 32'hBAD0_BAD1, 32'h0000_0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
